bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 11 +
 rtl/bus_arbiter_rr_sel.sv | 10 +
 rtl/bus_arbiter.sv | 101 ++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding, port ids and widths for the bus arbiter.
package bus_arbiter_pkg;
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int   AW    = 32;
    localparam int   DW    = 32;
endpackage

// File: rtl/bus_arbiter_rr_sel.sv
// arb_rr_sel: two-requester round-robin pick; on a tie the port not served last wins.
module arb_rr_sel
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    always_comb o_gnt = (&i_req) ? ((i_last == PORT1) ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bridge/DRAM bus between the CPU MEM stage (m0) and a DMA/loader (m1).
// Reads wait RD_LAT extra access cycles before bus_rdata is captured; writes take one access cycle.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          m0_req,
    input  logic          m0_wen,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_req,
    input  logic          m1_wen,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [AW-1:0] bus_addr,
    output logic          bus_wen,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          bus_busy
);
    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t        r_state, w_next;
    logic [1:0]    r_cnt;
    logic          r_id, r_wen, r_last, r_ack0, r_ack1;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
    logic [1:0]    w_elig, w_gnt;
    logic          w_grant, w_done, w_win, w_access;

    // a port whose ack is showing this cycle already got its data; its held req is stale
    assign w_elig   = {m1_req & ~r_ack1, m0_req & ~r_ack0};
    assign w_win    = w_gnt[1];
    assign w_access = (r_state == ACCESS);
    assign w_grant  = (r_state == IDLE) && (|w_gnt);
    assign w_done   = w_access && (r_wen || r_cnt == 2'd0);

    arb_rr_sel u_sel (
        .i_req (w_elig),
        .i_last(r_last),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = w_grant ? ACCESS : (w_done ? IDLE : r_state);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_cnt    <= 2'd0;
            r_id     <= PORT0;
            r_wen    <= 1'b0;
            r_last   <= PORT1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= w_done && (r_id == PORT0);
            r_ack1 <= w_done && (r_id == PORT1);
            if (w_grant) begin
                r_id    <= w_win;
                r_last  <= w_win;
                r_wen   <= w_win ? m1_wen : m0_wen;
                r_addr  <= w_win ? m1_addr : m0_addr;
                r_wdata <= w_win ? m1_wdata : m0_wdata;
                r_cnt   <= LAT;
            end else if (w_access && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_done && !r_wen && r_id == PORT0) r_rdata0 <= bus_rdata;
            if (w_done && !r_wen && r_id == PORT1) r_rdata1 <= bus_rdata;
        end
    end

    assign bus_busy  = w_access;
    assign bus_addr  = w_access ? r_addr : '0;
    assign bus_wdata = w_access ? r_wdata : '0;
    assign bus_wen   = w_access & r_wen;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign m0_ack    = r_ack0;
    assign m1_ack    = r_ack1;
    assign m0_stall  = m0_req & ~r_ack0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: three arbiters (RD_LAT 0/1/3) on shared stimulus, checked against a
// timestamp-based transaction model plus a directed vector table and corner sequences.
module tb_bus_arbiter;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic [31:0] o_rd0 [3], o_rd1 [3], o_addr [3], o_wdata [3];
    logic        o_ack0 [3], o_ack1 [3], o_stall [3], o_wen [3], o_busy [3];
    int          n_cmp = 0, n_bad = 0, t = 0;

    bit          m_act [3], m_port [3], m_wr [3], m_ackp [3], m_last [3];
    int          m_g [3], m_end [3], m_ackc [3];
    logic [31:0] m_a [3], m_d [3], m_rd0 [3], m_rd1 [3];

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1, rdat;
        logic        x_ack0, x_ack1, x_busy, x_wen, x_stall;
        logic [31:0] x_addr, x_wdata, x_rd0, x_rd1;
    } vec_t;
    vec_t tbl [9];

    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] H  = 32'h100;
    localparam logic [31:0] B  = 32'hDEADBEEF;
    localparam logic [31:0] A2 = 32'h200;
    localparam logic [31:0] D2 = 32'h12345678;

    always #5 cpu_clk = ~cpu_clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        bus_arbiter #(.RD_LAT(i == 2 ? 3 : i)) u_dut (
            .cpu_clk  (cpu_clk),
            .cpu_rst  (cpu_rst),
            .m0_req   (m0_req),
            .m0_wen   (m0_wen),
            .m0_addr  (m0_addr),
            .m0_wdata (m0_wdata),
            .m0_rdata (o_rd0[i]),
            .m0_ack   (o_ack0[i]),
            .m0_stall (o_stall[i]),
            .m1_req   (m1_req),
            .m1_wen   (m1_wen),
            .m1_addr  (m1_addr),
            .m1_wdata (m1_wdata),
            .m1_rdata (o_rd1[i]),
            .m1_ack   (o_ack1[i]),
            .bus_addr (o_addr[i]),
            .bus_wen  (o_wen[i]),
            .bus_wdata(o_wdata[i]),
            .bus_rdata(bus_rdata),
            .bus_busy (o_busy[i])
        );
    end

    function automatic int lat(int k);
        return k == 2 ? 3 : k;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    task automatic model_reset(int k);
        m_act[k]  = 1'b0;
        m_ackc[k] = -1;
        m_last[k] = 1'b1;
        m_rd0[k]  = 32'h0;
        m_rd1[k]  = 32'h0;
    endtask

    // A granted transaction owns the bus from grant+1 to grant+1+latency (0 for writes);
    // its ack shows in the cycle after that.
    task automatic model(int k);
        bit    ea0, ea1, e0, e1, pw;
        string p;
        ea0 = (m_ackc[k] == t) && !m_ackp[k];
        ea1 = (m_ackc[k] == t) && m_ackp[k];
        p   = $sformatf("d%0d@%0d ", k, t);
        chk({p, "busy"},  32'(o_busy[k]), 32'(m_act[k]));
        chk({p, "addr"},  o_addr[k], m_act[k] ? m_a[k] : 32'h0);
        chk({p, "wdata"}, o_wdata[k], m_act[k] ? m_d[k] : 32'h0);
        chk({p, "wen"},   32'(o_wen[k]), 32'(m_act[k] && m_wr[k] && t == m_g[k] + 1));
        chk({p, "ack0"},  32'(o_ack0[k]), 32'(ea0));
        chk({p, "ack1"},  32'(o_ack1[k]), 32'(ea1));
        chk({p, "rdata0"}, o_rd0[k], m_rd0[k]);
        chk({p, "rdata1"}, o_rd1[k], m_rd1[k]);
        chk({p, "stall"}, 32'(o_stall[k]), 32'(m0_req && !ea0));
        if (m_act[k] && t == m_end[k]) begin
            if (!m_wr[k] && !m_port[k]) m_rd0[k] = bus_rdata;
            if (!m_wr[k] && m_port[k])  m_rd1[k] = bus_rdata;
            m_ackc[k] = t + 1;
            m_ackp[k] = m_port[k];
            m_act[k]  = 1'b0;
        end else if (!m_act[k]) begin
            e0 = m0_req && !ea0;
            e1 = m1_req && !ea1;
            if (e0 || e1) begin
                pw        = (e0 && e1) ? !m_last[k] : e1;
                m_act[k]  = 1'b1;
                m_g[k]    = t;
                m_port[k] = pw;
                m_wr[k]   = pw ? m1_wen : m0_wen;
                m_a[k]    = pw ? m1_addr : m0_addr;
                m_d[k]    = pw ? m1_wdata : m0_wdata;
                m_end[k]  = t + 1 + (m_wr[k] ? 0 : lat(k));
                m_last[k] = pw;
            end
        end
        if (cpu_rst) model_reset(k);
    endtask

    task automatic half();
        @(negedge cpu_clk);
        for (int k = 0; k < 3; k++) model(k);
        t++;
    endtask

    task automatic adv();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1, rd);
        m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
        bus_rdata = rd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, Z);
        cpu_rst = 1'b1;
        half();
        adv();
        cpu_rst = 1'b0;
    endtask

    initial begin
        int q [$];
        int first [3];
        int w;
        tbl[0] = '{1'b1, 1'b0, H, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Z, Z, Z, Z};
        tbl[1] = '{1'b1, 1'b0, H, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, H, Z, Z, Z};
        tbl[2] = '{1'b1, 1'b0, H, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, H, Z, Z, Z};
        tbl[3] = '{1'b1, 1'b0, H, Z, 1'b0, 1'b0, Z, Z, B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, B, Z};
        tbl[4] = '{1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, B, Z};
        tbl[5] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, A2, D2, B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, B, Z};
        tbl[6] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, A2, D2, B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A2, D2, B, Z};
        tbl[7] = '{1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Z, Z, B, Z};
        tbl[8] = '{1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, B, Z};

        drive(1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, Z);
        cpu_rst = 1'b1;
        adv();
        for (int k = 0; k < 3; k++) model_reset(k);
        half();
        chk("reset busy", 32'(o_busy[1]), 32'h0);
        chk("reset addr", o_addr[1], Z);
        chk("reset ack0", 32'(o_ack0[1]), 32'h0);
        chk("reset rdata0", o_rd0[1], Z);
        chk("reset rdata1", o_rd1[1], Z);
        adv();
        cpu_rst = 1'b0;

        // m0 read at 0x100 then m1 write at 0x200, on the RD_LAT=1 instance
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].rdat);
            half();
            chk($sformatf("row%0d ack0", i),  32'(o_ack0[1]),  32'(tbl[i].x_ack0));
            chk($sformatf("row%0d ack1", i),  32'(o_ack1[1]),  32'(tbl[i].x_ack1));
            chk($sformatf("row%0d busy", i),  32'(o_busy[1]),  32'(tbl[i].x_busy));
            chk($sformatf("row%0d wen", i),   32'(o_wen[1]),   32'(tbl[i].x_wen));
            chk($sformatf("row%0d stall", i), 32'(o_stall[1]), 32'(tbl[i].x_stall));
            chk($sformatf("row%0d addr", i),  o_addr[1],  tbl[i].x_addr);
            chk($sformatf("row%0d wdata", i), o_wdata[1], tbl[i].x_wdata);
            chk($sformatf("row%0d rdata0", i), o_rd0[1], tbl[i].x_rd0);
            chk($sformatf("row%0d rdata1", i), o_rd1[1], tbl[i].x_rd1);
            adv();
        end

        // single-cycle read request: ack lands at N+2+RD_LAT on each instance
        do_reset();
        drive(1'b1, 1'b0, 32'h40, Z, 1'b0, 1'b0, Z, Z, 32'hCAFE0031);
        for (int k = 0; k < 3; k++) first[k] = -1;
        half();
        adv();
        m0_req = 1'b0;
        for (int c = 1; c < 9; c++) begin
            half();
            for (int k = 0; k < 3; k++) if (o_ack0[k] && first[k] < 0) first[k] = c;
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lat%0d ack cycle", lat(k)), 32'(first[k]), 32'(2 + lat(k)));
            chk($sformatf("lat%0d rdata", lat(k)), o_rd0[k], 32'hCAFE0031);
        end

        // both ports read continuously from reset: grants alternate 0,1,0
        do_reset();
        drive(1'b1, 1'b0, 32'h10, Z, 1'b1, 1'b0, 32'h20, Z, 32'h0BAD0001);
        for (int c = 0; c < 20 && q.size() < 3; c++) begin
            half();
            if (o_ack0[1]) q.push_back(0);
            if (o_ack1[1]) q.push_back(1);
            adv();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("rr count", 32'(q.size()), 32'd3);
        for (int j = 0; j < 3 && j < q.size(); j++)
            chk($sformatf("rr order%0d", j), 32'(q[j]), (j == 1) ? 32'd1 : 32'd0);

        // reset lands in the first access cycle of a write
        do_reset();
        drive(1'b1, 1'b1, 32'h80, 32'h55, 1'b0, 1'b0, Z, Z, Z);
        half();
        adv();
        cpu_rst = 1'b1;
        m0_req  = 1'b0;
        half();
        chk("rst wr first wen", 32'(o_wen[1]), 32'd1);
        adv();
        cpu_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half();
            chk($sformatf("rst wr wen%0d", c), 32'(o_wen[1]), 32'd0);
            chk($sformatf("rst wr busy%0d", c), 32'(o_busy[1]), 32'd0);
            chk($sformatf("rst wr ack%0d", c), 32'(o_ack0[1]), 32'd0);
            adv();
        end

        // m0 never lets go; m1 must still be served within one m0 transaction
        do_reset();
        drive(1'b1, 1'b0, 32'h30, Z, 1'b0, 1'b0, Z, Z, 32'h77);
        for (int c = 0; c < 3; c++) begin
            half();
            adv();
        end
        m1_req  = 1'b1;
        m1_addr = 32'h300;
        w = -1;
        for (int c = 0; c < 12 && w < 0; c++) begin
            half();
            if (o_ack1[1]) w = c;
            adv();
        end
        m1_req = 1'b0;
        chk("starve wait bounded", 32'(w >= 0 && w <= 5), 32'd1);

        for (int c = 0; c < 2500; c++) begin
            cpu_rst   = ($urandom_range(0, 149) == 0);
            m0_req    = ($urandom_range(0, 2) != 0);
            m0_wen    = 1'($urandom_range(0, 1));
            m0_addr   = $urandom;
            m0_wdata  = $urandom;
            m1_req    = ($urandom_range(0, 2) == 0);
            m1_wen    = 1'($urandom_range(0, 1));
            m1_addr   = $urandom;
            m1_wdata  = $urandom;
            bus_rdata = $urandom;
            half();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
